bq_coef_sched: RTL and testbench

Wishbone-configured coefficient scheduler for the biquad datapath. Software writes a shadow bank of five coefficients, then issues a commit. The block copies shadow to active atomically on the next filter sample strobe, so the biquad never runs a sample with a mix of old and new coefficients. It sits between the Wishbone bus and the biquad coefficient inputs, replacing a direct register file.

---
 rtl/bq_coef_sched.sv | 114 +++++++++++
 tb/tb_bq_coef_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bq_coef_sched.sv
// Biquad coefficient scheduler: Wishbone-written shadow bank, copied to the
// active bank atomically on the sample strobe that follows a commit.
module bq_coef_sched #(
   parameter int COEFWIDTH = 16,
   parameter int AW        = 4
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [31:0]          wb_adr_i,
   input  logic [31:0]          wb_dat_i,
   output logic [31:0]          wb_dat_o,
   output logic                 wb_ack_o,
   input  logic                 sample_stb_i,
   output logic [COEFWIDTH-1:0] a11_o,
   output logic [COEFWIDTH-1:0] a12_o,
   output logic [COEFWIDTH-1:0] b10_o,
   output logic [COEFWIDTH-1:0] b11_o,
   output logic [COEFWIDTH-1:0] b12_o,
   output logic                 coef_upd_o,
   output logic                 pending_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} state_t;

   state_t        r_state, w_state_nxt;
   logic [15:0]   r_shadow [5];
   logic [15:0]   r_active [5];
   logic [15:0]   r_commit_cnt;
   logic          r_err;
   logic          r_ack;
   logic [31:0]   r_dat;

   logic [AW-1:0] w_idx;
   logic [2:0]    w_sidx;
   logic          w_access, w_wr, w_ctrl_wr, w_commit, w_err_clr, w_shadow_wr, w_load;
   logic [31:0]   w_rdata;
   logic          w_unused;

   // Bus handshake: ack <= cyc & stb & ~ack, so every access sees one wait
   // state and exactly one ack cycle; writes land on the acking edge.
   assign w_idx       = wb_adr_i[AW+1:2];
   assign w_sidx      = w_idx[2:0];
   assign w_access    = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_wr        = w_access & wb_we_i;
   assign w_ctrl_wr   = w_wr & (w_idx == AW'(5));
   assign w_commit    = w_ctrl_wr & wb_dat_i[0];
   assign w_err_clr   = w_ctrl_wr & wb_dat_i[1];
   assign w_shadow_wr = w_wr & (w_idx < AW'(5));
   assign w_load      = (r_state == ST_PENDING) & sample_stb_i;
   assign w_unused    = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0], wb_dat_i[31:16]};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_commit) w_state_nxt = ST_PENDING;
         ST_PENDING: if (sample_stb_i) w_state_nxt = ST_APPLY;
         ST_APPLY:   w_state_nxt = w_commit ? ST_PENDING : ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rdata = '0;
      if (w_idx < AW'(5))
         w_rdata = {16'h0, r_shadow[w_sidx]};
      else if (w_idx == AW'(6))
         w_rdata = {r_commit_cnt, 14'h0, r_err, (r_state == ST_PENDING)};
      else if (w_idx == AW'(7))
         w_rdata = {r_active[2], r_active[0]};
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state      <= ST_IDLE;
         r_commit_cnt <= '0;
         r_err        <= 1'b0;
         r_ack        <= 1'b0;
         r_dat        <= '0;
         for (int i = 0; i < 5; i++) begin
            r_shadow[i] <= (i == 2) ? 16'h7FFF : 16'h0000;
            r_active[i] <= (i == 2) ? 16'h7FFF : 16'h0000;
         end
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_access;
         r_dat   <= (w_access & ~wb_we_i) ? w_rdata : 32'h0;
         // Shadow is frozen while a commit waits so the applied bank is the committed one.
         if (w_shadow_wr && r_state != ST_PENDING)
            r_shadow[w_sidx] <= wb_dat_i[15:0];
         if (w_err_clr)
            r_err <= 1'b0;
         else if (w_shadow_wr && r_state == ST_PENDING)
            r_err <= 1'b1;
         if (w_load) begin
            for (int i = 0; i < 5; i++) r_active[i] <= r_shadow[i];
            r_commit_cnt <= r_commit_cnt + 16'd1;
         end
      end
   end

   assign wb_ack_o   = r_ack;
   assign wb_dat_o   = r_dat;
   assign coef_upd_o = (r_state == ST_APPLY);
   assign pending_o  = (r_state == ST_PENDING);
   assign a11_o      = r_active[0][15 -: COEFWIDTH];
   assign a12_o      = r_active[1][15 -: COEFWIDTH];
   assign b10_o      = r_active[2][15 -: COEFWIDTH];
   assign b11_o      = r_active[3][15 -: COEFWIDTH];
   assign b12_o      = r_active[4][15 -: COEFWIDTH];

endmodule

// File: tb/tb_bq_coef_sched.sv
// Self-checking bench for bq_coef_sched: a 16-bit instance plus a 12-bit
// instance sharing the same bus and strobe stimulus.
module tb_bq_coef_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sstb = 1'b0;
   logic [31:0] adr = '0, dat_w = '0;
   logic [31:0] dat_o, dat12_o;
   logic        ack, ack12;
   logic [15:0] a11, a12, b10, b11, b12;
   logic [11:0] c11, c12, d10, d11, d12;
   logic        upd, upd12, pend, pend12;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   bq_coef_sched #(.COEFWIDTH(16), .AW(4)) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_o), .wb_ack_o(ack),
      .sample_stb_i(sstb), .a11_o(a11), .a12_o(a12), .b10_o(b10), .b11_o(b11),
      .b12_o(b12), .coef_upd_o(upd), .pending_o(pend));

   bq_coef_sched #(.COEFWIDTH(12), .AW(4)) u_dut12 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat12_o), .wb_ack_o(ack12),
      .sample_stb_i(sstb), .a11_o(c11), .a12_o(c12), .b10_o(d10), .b11_o(d11),
      .b12_o(d12), .coef_upd_o(upd12), .pending_o(pend12));

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic wb_xfer(input logic w, input int idx, input logic [31:0] d,
                          input logic with_stb, output logic [31:0] rd);
      int n;
      logic [31:0] a;
      @(negedge clk);
      a      = $urandom();
      a[5:2] = 4'(idx);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sstb = with_stb;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ack && n < 4);
      n_checks++;
      if (ack !== 1'b1) begin
         n_fail++;
         $display("FAIL wb_ack_timeout idx=%0d: ack=%b required 1", idx, ack);
      end
      rd = dat_o;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sstb = 1'b0;
   endtask

   task automatic wb_write(input int idx, input logic [31:0] d);
      logic [31:0] rd;
      wb_xfer(1'b1, idx, d, 1'b0, rd);
   endtask

   task automatic wb_read(input int idx, output logic [31:0] rd);
      wb_xfer(1'b0, idx, 32'h0, 1'b0, rd);
   endtask

   // Returns at the negedge just after the strobe edge.
   task automatic pulse_stb();
      @(negedge clk); sstb = 1'b1;
      @(negedge clk); sstb = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] e;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      n_checks++;
      if ({a11, a12, b10, b11, b12, upd, pend, ack, dat_o} !==
          {16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_outputs: a11=%h a12=%h b10=%h b11=%h b12=%h upd=%b pend=%b ack=%b dat=%h required b10=7fff rest 0",
                  a11, a12, b10, b11, b12, upd, pend, ack, dat_o);
      end
      n_checks++;
      if (d10 !== 12'h7FF) begin
         n_fail++; $display("FAIL reset_b10_w12: got %h required 7ff", d10);
      end
      // STATUS read with stb held: ack on first edge, low on the next.
      exp_q.push_back(32'h0);
      @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0018;
      @(posedge clk); #1;
      n_checks++;
      if (ack !== 1'b1) begin
         n_fail++; $display("FAIL ack_first_edge: got %b required 1", ack);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (dat_o !== e) begin
         n_fail++; $display("FAIL reset_status: got %h required %h", dat_o, e);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ack !== 1'b0) begin
         n_fail++; $display("FAIL ack_single_cycle: got %b required 0", ack);
      end
      @(negedge clk); cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic test_commit();
      logic [31:0] rd, e;
      int idx_l[4] = '{6, 7, 0, 5};
      wb_write(0, 32'h4001);
      wb_write(2, 32'h2000);
      wb_write(5, 32'h1);
      n_checks++;
      if ({pend, a11, b10} !== {1'b1, 16'h0, 16'h7FFF}) begin
         n_fail++; $display("FAIL commit_pending: pend=%b a11=%h b10=%h required 1 0000 7fff", pend, a11, b10);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({upd, a11, b10} !== {1'b0, 16'h0, 16'h7FFF}) begin
            n_fail++; $display("FAIL commit_hold cyc%0d: upd=%b a11=%h b10=%h required 0 0000 7fff", i, upd, a11, b10);
         end
      end
      pulse_stb();
      n_checks++;
      if ({upd, pend, a11, b10} !== {1'b1, 1'b0, 16'h4001, 16'h2000}) begin
         n_fail++; $display("FAIL commit_apply: upd=%b pend=%b a11=%h b10=%h required 1 0 4001 2000", upd, pend, a11, b10);
      end
      n_checks++;
      if ({c11, d10} !== {12'h400, 12'h200}) begin
         n_fail++; $display("FAIL commit_apply_w12: a11=%h b10=%h required 400 200", c11, d10);
      end
      @(negedge clk);
      n_checks++;
      if (upd !== 1'b0) begin
         n_fail++; $display("FAIL commit_upd_pulse: upd=%b required 0", upd);
      end
      exp_q.push_back(32'h0001_0000);
      exp_q.push_back(32'h2000_4001);
      exp_q.push_back(32'h0000_4001);
      exp_q.push_back(32'h0);
      foreach (idx_l[i]) begin
         wb_read(idx_l[i], rd);
         e = exp_q.pop_front();
         n_checks++;
         if (rd !== e) begin
            n_fail++; $display("FAIL commit_read idx=%0d: got %h required %h", idx_l[i], rd, e);
         end
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] rd, e;
      wb_write(1, 32'h0055);
      wb_xfer(1'b1, 5, 32'h1, 1'b1, rd);
      repeat (2) @(negedge clk);
      n_checks++;
      if ({pend, upd, a12} !== {1'b1, 1'b0, 16'h0}) begin
         n_fail++; $display("FAIL same_cycle_wait: pend=%b upd=%b a12=%h required 1 0 0000", pend, upd, a12);
      end
      pulse_stb();
      n_checks++;
      if ({upd, a12} !== {1'b1, 16'h0055}) begin
         n_fail++; $display("FAIL same_cycle_apply: upd=%b a12=%h required 1 0055", upd, a12);
      end
      exp_q.push_back(32'h0002_0000);
      wb_read(6, rd);
      e = exp_q.pop_front();
      n_checks++;
      if (rd !== e) begin
         n_fail++; $display("FAIL same_cycle_status: got %h required %h", rd, e);
      end
   endtask

   task automatic test_err();
      logic [31:0] rd, e;
      int idx_l[5] = '{1, 6, 6, 6, 6};
      wb_write(5, 32'h1);
      wb_write(1, 32'h1234);
      exp_q.push_back(32'h0000_0055);
      exp_q.push_back(32'h0002_0003);
      for (int i = 0; i < 2; i++) begin
         wb_read(idx_l[i], rd);
         e = exp_q.pop_front();
         n_checks++;
         if (rd !== e) begin
            n_fail++; $display("FAIL err_set_read idx=%0d: got %h required %h", idx_l[i], rd, e);
         end
      end
      wb_write(5, 32'h2);
      exp_q.push_back(32'h0002_0001);
      wb_read(6, rd);
      e = exp_q.pop_front();
      n_checks++;
      if (rd !== e) begin
         n_fail++; $display("FAIL err_clear: got %h required %h", rd, e);
      end
      pulse_stb();
      n_checks++;
      if (a12 !== 16'h0055) begin
         n_fail++; $display("FAIL err_dropped_write: a12=%h required 0055", a12);
      end
      // Commit and error clear in one CTRL write.
      wb_write(5, 32'h1);
      wb_write(0, 32'h7777);
      wb_write(5, 32'h3);
      exp_q.push_back(32'h0003_0001);
      wb_read(6, rd);
      e = exp_q.pop_front();
      n_checks++;
      if (rd !== e) begin
         n_fail++; $display("FAIL commit_and_clear: got %h required %h", rd, e);
      end
      pulse_stb();
      n_checks++;
      if (a11 !== 16'h4001) begin
         n_fail++; $display("FAIL commit_and_clear_apply: a11=%h required 4001", a11);
      end
   endtask

   task automatic test_double_commit();
      logic [31:0] rd, e;
      int n_upd;
      wb_write(3, 32'h0777);
      wb_write(5, 32'h1);
      wb_write(5, 32'h1);
      pulse_stb();
      n_upd = int'(upd);
      repeat (3) begin @(negedge clk); n_upd += int'(upd); end
      pulse_stb();
      n_upd += int'(upd);
      repeat (2) begin @(negedge clk); n_upd += int'(upd); end
      n_checks++;
      if (n_upd != 1 || b11 !== 16'h0777) begin
         n_fail++; $display("FAIL double_commit: upd_pulses=%0d b11=%h required 1 0777", n_upd, b11);
      end
      exp_q.push_back(32'h0005_0000);
      wb_read(6, rd);
      e = exp_q.pop_front();
      n_checks++;
      if (rd !== e) begin
         n_fail++; $display("FAIL double_commit_cnt: got %h required %h", rd, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, e;
      wb_write(4, 32'h0F0F);
      wb_write(5, 32'h1);
      @(negedge clk); sstb = 1'b1;
      @(negedge clk); sstb = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0014; dat_w = 32'h1;
      n_checks++;
      if ({upd, b12} !== {1'b1, 16'h0F0F}) begin
         n_fail++; $display("FAIL b2b_apply: upd=%b b12=%h required 1 0f0f", upd, b12);
      end
      @(posedge clk); #1;
      @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
      n_checks++;
      if ({pend, upd} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_commit_in_apply: pend=%b upd=%b required 1 0", pend, upd);
      end
      pulse_stb();
      n_checks++;
      if (upd !== 1'b1) begin
         n_fail++; $display("FAIL b2b_second_apply: upd=%b required 1", upd);
      end
      exp_q.push_back(32'h0007_0000);
      wb_read(6, rd);
      e = exp_q.pop_front();
      n_checks++;
      if (rd !== e) begin
         n_fail++; $display("FAIL b2b_cnt: got %h required %h", rd, e);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rd, e;
      @(negedge clk);
      u_dut.r_commit_cnt   = 16'hFFFE;
      u_dut12.r_commit_cnt = 16'hFFFE;
      exp_q.push_back(32'hFFFF_0000);
      exp_q.push_back(32'h0000_0000);
      for (int i = 0; i < 2; i++) begin
         wb_write(5, 32'h1);
         pulse_stb();
         wb_read(6, rd);
         e = exp_q.pop_front();
         n_checks++;
         if (rd !== e) begin
            n_fail++; $display("FAIL wrap_cnt step%0d: got %h required %h", i, rd, e);
         end
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd, e;
      int idx_l[4] = '{9, 15, 3, 8};
      wb_write(9, 32'hFFFF_FFFF);
      wb_write(8, 32'h0000_0003);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_0777);
      exp_q.push_back(32'h0);
      foreach (idx_l[i]) begin
         wb_read(idx_l[i], rd);
         e = exp_q.pop_front();
         n_checks++;
         if (rd !== e) begin
            n_fail++; $display("FAIL unmapped idx=%0d: got %h required %h", idx_l[i], rd, e);
         end
      end
      n_checks++;
      if (pend !== 1'b0) begin
         n_fail++; $display("FAIL unmapped_no_commit: pend=%b required 0", pend);
      end
   endtask

   task automatic test_width_and_reset();
      logic [31:0] rd, e;
      int idx_l[4] = '{6, 0, 2, 7};
      wb_write(3, 32'hABCD);
      wb_write(5, 32'h1);
      pulse_stb();
      n_checks++;
      if ({b11, d11} !== {16'hABCD, 12'hABC}) begin
         n_fail++; $display("FAIL coefwidth: b11=%h b11_w12=%h required abcd abc", b11, d11);
      end
      wb_write(0, 32'h1111);
      wb_write(5, 32'h1);
      @(negedge clk); rst = 1'b1;
      #1;
      n_checks++;
      if ({pend, upd, a11, a12, b10, b11, b12} !==
          {1'b0, 1'b0, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0}) begin
         n_fail++; $display("FAIL reset_mid_pending: pend=%b upd=%b a11=%h a12=%h b10=%h b11=%h b12=%h required 0 0 0 0 7fff 0 0",
                            pend, upd, a11, a12, b10, b11, b12);
      end
      @(negedge clk); rst = 1'b0;
      pulse_stb();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_7FFF);
      exp_q.push_back(32'h7FFF_0000);
      foreach (idx_l[i]) begin
         wb_read(idx_l[i], rd);
         e = exp_q.pop_front();
         n_checks++;
         if (rd !== e) begin
            n_fail++; $display("FAIL post_reset_read idx=%0d: got %h required %h", idx_l[i], rd, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_same_cycle();
      test_err();
      test_double_commit();
      test_back_to_back();
      test_wrap();
      test_unmapped();
      test_width_and_reset();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
